stream_capture_serializer: RTL and testbench
============================================

// Module: stream_capture_serializer
// PURPOSE
//  Synthesizable successor to the simulation-only output capture of the kernel
//  wrapper. Passively taps NUM_CH ap_fifo-style kernel output streams (write strobe
//  + din), buffers each in a per-channel FIFO, and serializes the captured words onto
//  the narrow board pins (data_out/data_valid). Never back-pressures the kernel;
//  overflow is dropped and counted. Sits in wrapper between kernel top and pin I/O.
// PARAMETERS
//  NUM_CH     8   number of tapped channels (1..16; header is one nibble)
//  DATA_W     32  width of each channel din; must be a multiple of OUT_W
//  DEPTH      4   per-channel FIFO depth in words (power of 2, >=2)
//  OUT_W      4   serial output width; NIB = DATA_W/OUT_W data beats per word
// PORTS
//  ap_clk       in   1             single clock, all logic rising-edge
//  ap_rst_n     in   1             asynchronous, active-low reset
//  cap_en       in   1             1 = capture enabled; 0 = writes ignored (not drops)
//  clear_stats  in   1             1-cycle pulse: clear drop_cnt and ovf_sticky
//  ch_write     in   NUM_CH        per-channel write strobe (kernel *_write)
//  ch_din       in   NUM_CH*DATA_W per-channel data, ch i at [i*DATA_W +: DATA_W]
//  data_out     out  OUT_W         serialized beat
//  data_valid   out  1             data_out carries a frame beat
//  frame_start  out  1             high on header beat only
//  drop_cnt     out  16            total dropped words, saturating at 16'hFFFF
//  ovf_sticky   out  NUM_CH        per-channel sticky overflow flag
//  probe_out    out  1             = |ovf_sticky
// BEHAVIOUR
//  - Reset (async, immediate): data_out=0, data_valid=0, frame_start=0, drop_cnt=0,
//    ovf_sticky=0, all FIFOs empty, FSM=IDLE, RR pointer=NUM_CH-1. Frame in
//    progress is aborted, never resumed.
//  - Capture: on edge with cap_en & ch_write[i]: push if FIFO i not full (occupancy
//    before the edge), else drop: drop_cnt+1 (saturating), ovf_sticky[i]=1. No
//    full-bypass even if the same edge pops. Multiple drops in one edge add their count.
//  - clear_stats: applied first, then same-edge drops counted (clear+1 drop -> 1).
//  - Frame: HDR beat = channel index (zero-extended to OUT_W), then NIB beats of the
//    word MSB nibble first; data_valid high on every beat, no gaps within a frame.
//  - FSM: IDLE -> HDR when any FIFO non-empty; round-robin pick starting at RR+1,
//    pop on HDR entry, RR=picked. HDR -> DATA(beat 0..NIB-1) -> [PAR] -> HDR if
//    another FIFO non-empty (back-to-back frames, zero idle cycles) else IDLE.
//  - Latency: word captured at edge E, FSM idle -> header beat registered at E+1.
//  - All outputs registered; data_out=0 whenever data_valid=0.
//  - cap_en deassert mid-frame: current and buffered frames still drain.
// CONFIGURATION
//  - SER_PARITY_EN defined: one extra PAR beat after data = XOR of the NIB data
//    nibbles; frame = NIB+2 beats. Undefined: no PAR beat, frame = NIB+1 beats.
// TESTING (NUM_CH=8, DATA_W=32, DEPTH=4, OUT_W=4)
//  1 idle, ch3 writes 0xDEADBEEF -> beats 3,D,E,A,D,B,E,E,F, valid 9 cycles, frame_start
//    on beat 0 only, header one edge after capture.
//  2 all 8 ch write 0x11111111*i same edge -> frames ch0..ch7 in order, back-to-back,
//    72 contiguous valid cycles, drop_cnt=0.
//  3 ch0 writes 8 consecutive edges -> 5 frames (words 1-5), drop_cnt=3,
//    ovf_sticky=8'h01, probe_out=1.
//  4 SER_PARITY_EN, ch5 writes 0x12345678 -> beats 5,1,2,3,4,5,6,7,8,8 (10 cycles);
//    without macro 9 beats, no trailing 8.
//  5 ap_rst_n low during 4th data beat -> data_out=0/data_valid=0 without clock edge;
//    after release no output until a new write.
//  6 cap_en=0 with writes -> no frames, drop_cnt unchanged; clear_stats on same edge as
//    a ch2 drop (drop_cnt was 5) -> drop_cnt=1, ovf_sticky[2]=1.

Source files
------------

// File: rtl/stream_capture_serializer.sv
// Taps NUM_CH ap_fifo-style kernel output streams, buffers each in a small FIFO and
// serializes captured words as header+nibble frames. Optional macro: SER_PARITY_EN.
module stream_capture_serializer #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int OUT_W  = 4
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic                     cap_en,
  input  logic                     clear_stats,
  input  logic [NUM_CH-1:0]        ch_write,
  input  logic [NUM_CH*DATA_W-1:0] ch_din,
  output logic [OUT_W-1:0]         data_out,
  output logic                     data_valid,
  output logic                     frame_start,
  output logic [15:0]              drop_cnt,
  output logic [NUM_CH-1:0]        ovf_sticky,
  output logic                     probe_out
);

  localparam int NIB    = DATA_W / OUT_W;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BEAT_W = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_PAR} state_t;

  logic [DATA_W-1:0] r_mem    [NUM_CH][DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr [NUM_CH];
  logic [PTR_W-1:0]  r_rd_ptr [NUM_CH];
  logic [CNT_W-1:0]  r_count  [NUM_CH];

  state_t            r_state;
  logic [CH_W-1:0]   r_rr;
  logic [BEAT_W-1:0] r_beat;
  logic [DATA_W-1:0] r_shift;
`ifdef SER_PARITY_EN
  logic [OUT_W-1:0]  r_par;
`endif

  logic [NUM_CH-1:0] w_nonempty, w_full, w_push, w_drop, w_pop_mask;
  logic [CH_W-1:0]   w_pick;
  logic              w_found, w_last_beat, w_slot, w_pop;
  logic [DATA_W-1:0] w_pop_data;
  logic [4:0]        w_drop_num;
  logic [15:0]       w_drop_base, w_drop_nxt;
  logic [16:0]       w_drop_sum;
  logic [NUM_CH-1:0] w_sticky_nxt;

  // NOTE: every combinational output gets a default before any branch so no latch is inferred.
  always_comb begin
    w_nonempty = '0;
    w_full     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_nonempty[i] = (r_count[i] != '0);
      w_full[i]     = (r_count[i] == CNT_W'(DEPTH));
    end
    w_push = {NUM_CH{cap_en}} & ch_write & ~w_full;
    w_drop = {NUM_CH{cap_en}} & ch_write &  w_full;
  end

  // Round-robin search starts one past the last channel served.
  always_comb begin
    w_pick  = r_rr;
    w_found = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      if (!w_found && w_nonempty[(int'(r_rr) + k) % NUM_CH]) begin
        w_found = 1'b1;
        w_pick  = CH_W'((int'(r_rr) + k) % NUM_CH);
      end
    end
  end

  always_comb begin
    w_last_beat = (r_state == S_DATA) && (r_beat == BEAT_W'(NIB - 1));
`ifdef SER_PARITY_EN
    w_slot = (r_state == S_IDLE) || (r_state == S_PAR);
`else
    w_slot = (r_state == S_IDLE) || w_last_beat;
`endif
    w_pop      = w_slot && w_found;
    w_pop_data = r_mem[w_pick][r_rd_ptr[w_pick]];
    w_pop_mask = '0;
    for (int i = 0; i < NUM_CH; i++) w_pop_mask[i] = w_pop && (w_pick == CH_W'(i));
  end

  always_comb begin
    w_drop_num = '0;
    for (int i = 0; i < NUM_CH; i++) w_drop_num = w_drop_num + 5'(w_drop[i]);
    w_drop_base  = clear_stats ? 16'd0 : drop_cnt;
    w_drop_sum   = {1'b0, w_drop_base} + 17'(w_drop_num);
    w_drop_nxt   = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    w_sticky_nxt = (clear_stats ? '0 : ovf_sticky) | w_drop;
  end

  // NOTE: FIFO storage carries no reset; occupancy counters alone define validity.
  always_ff @(posedge ap_clk) begin
    for (int i = 0; i < NUM_CH; i++)
      if (w_push[i]) r_mem[i][r_wr_ptr[i]] <= ch_din[i*DATA_W +: DATA_W];
  end

  // NOTE: state registers use non-blocking assignments so every block sees pre-edge values.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_wr_ptr[i] <= '0;
        r_rd_ptr[i] <= '0;
        r_count[i]  <= '0;
      end
      drop_cnt   <= '0;
      ovf_sticky <= '0;
      probe_out  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_push[i])     r_wr_ptr[i] <= r_wr_ptr[i] + PTR_W'(1);
        if (w_pop_mask[i]) r_rd_ptr[i] <= r_rd_ptr[i] + PTR_W'(1);
        case ({w_push[i], w_pop_mask[i]})
          2'b10:   r_count[i] <= r_count[i] + CNT_W'(1);
          2'b01:   r_count[i] <= r_count[i] - CNT_W'(1);
          default: ;
        endcase
      end
      drop_cnt   <= w_drop_nxt;
      ovf_sticky <= w_sticky_nxt;
      probe_out  <= |w_sticky_nxt;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state     <= S_IDLE;
      r_rr        <= CH_W'(NUM_CH - 1);
      r_beat      <= '0;
      r_shift     <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_start <= 1'b0;
`ifdef SER_PARITY_EN
      r_par       <= '0;
`endif
    end else begin
      frame_start <= 1'b0;
      if (w_pop) begin
        r_state     <= S_HDR;
        r_rr        <= w_pick;
        r_shift     <= w_pop_data;
        data_out    <= OUT_W'(w_pick);
        data_valid  <= 1'b1;
        frame_start <= 1'b1;
`ifdef SER_PARITY_EN
        r_par       <= '0;
`endif
      end else if (r_state == S_HDR || (r_state == S_DATA && !w_last_beat)) begin
        r_state    <= S_DATA;
        r_beat     <= (r_state == S_HDR) ? '0 : r_beat + BEAT_W'(1);
        r_shift    <= r_shift << OUT_W;
        data_out   <= r_shift[DATA_W-1 -: OUT_W];
        data_valid <= 1'b1;
`ifdef SER_PARITY_EN
        r_par      <= r_par ^ r_shift[DATA_W-1 -: OUT_W];
      end else if (r_state == S_DATA) begin
        r_state    <= S_PAR;
        data_out   <= r_par;
        data_valid <= 1'b1;
`endif
      end else begin
        r_state    <= S_IDLE;
        data_out   <= '0;
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_capture_serializer.sv
// Bench for stream_capture_serializer: frames observed on the pins are compared
// cycle by cycle against a queue-based frame model; SER_PARITY_EN selects parity.
module tb_stream_capture_serializer;
  localparam int NUM_CH = 8, DATA_W = 32, DEPTH = 4, OUT_W = 4;
  localparam int NIB = DATA_W / OUT_W;

  logic                     ap_clk = 1'b0;
  logic                     ap_rst_n, cap_en, clear_stats;
  logic [NUM_CH-1:0]        ch_write;
  logic [NUM_CH*DATA_W-1:0] ch_din;
  logic [OUT_W-1:0]         data_out;
  logic                     data_valid, frame_start;
  logic [15:0]              drop_cnt;
  logic [NUM_CH-1:0]        ovf_sticky;
  logic                     probe_out;

  stream_capture_serializer #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .OUT_W(OUT_W)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .cap_en(cap_en), .clear_stats(clear_stats),
    .ch_write(ch_write), .ch_din(ch_din), .data_out(data_out), .data_valid(data_valid),
    .frame_start(frame_start), .drop_cnt(drop_cnt), .ovf_sticky(ovf_sticky),
    .probe_out(probe_out)
  );

  always #5 ap_clk = ~ap_clk;

  int          n_pass = 0, n_total = 0;
  bit          mon_en = 1'b0;
  logic [5:0]  trace[$];
  logic [5:0]  exp_q[$];
  int          rr_last;
  logic [31:0] burst_words[NUM_CH];
  logic [31:0] seq_words[10];

  always @(negedge ap_clk) if (mon_en) trace.push_back({data_valid, frame_start, data_out});

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [3:0] nib_of(input logic [31:0] w, input int k);
    return 4'((w >> (4 * (NIB - 1 - k))) & 32'hF);
  endfunction

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(6'b0);
  endtask

  task automatic add_frame(input int ch, input logic [31:0] w);
    logic [3:0] par;
    par = 4'h0;
    exp_q.push_back({1'b1, 1'b1, 4'(ch)});
    for (int k = 0; k < NIB; k++) begin
      par ^= nib_of(w, k);
      exp_q.push_back({1'b1, 1'b0, nib_of(w, k)});
    end
`ifdef SER_PARITY_EN
    exp_q.push_back({1'b1, 1'b0, par});
`endif
  endtask

  task automatic start_trace();
    trace.delete();
    exp_q.delete();
    mon_en = 1'b1;
  endtask

  task automatic finish_trace(input string tag);
    int n;
    n = exp_q.size();
    for (int c = 0; c < n + 4 && trace.size() < n; c++) tick();
    mon_en = 1'b0;
    if (trace.size() < n) check({tag, "_len"}, trace.size(), n);
    else for (int i = 0; i < n; i++) check($sformatf("%s[%0d]", tag, i), trace[i], exp_q[i]);
  endtask

  // One write edge on every channel in mask; frames leave in round-robin order.
  task automatic do_burst(input logic [NUM_CH-1:0] mask, input string tag);
    int last;
    last = rr_last;
    start_trace();
    add_idle(2);
    for (int k = 1; k <= NUM_CH; k++) begin
      if (mask[(rr_last + k) % NUM_CH]) begin
        add_frame((rr_last + k) % NUM_CH, burst_words[(rr_last + k) % NUM_CH]);
        last = (rr_last + k) % NUM_CH;
      end
    end
    rr_last = last;
    add_idle(2);
    ch_write = mask;
    for (int c = 0; c < NUM_CH; c++) ch_din[c*DATA_W +: DATA_W] = burst_words[c];
    tick();
    ch_write = '0;
    finish_trace(tag);
  endtask

  initial begin
    ap_rst_n = 1'b0; cap_en = 1'b1; clear_stats = 1'b0; ch_write = '0; ch_din = '0;
    rr_last = NUM_CH - 1;
    #3;
    check("rst_valid", data_valid, 0);
    check("rst_data", data_out, 0);
    check("rst_fs", frame_start, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_ovf", ovf_sticky, 0);
    check("rst_probe", probe_out, 0);
    #10 ap_rst_n = 1'b1;
    tick();

    // All channels on one edge: ch0..ch7 back-to-back.
    for (int c = 0; c < NUM_CH; c++) burst_words[c] = 32'h1111_1111 * c;
    do_burst(8'hFF, "all_ch");
    check("all_ch_drop", drop_cnt, 0);

    for (int c = 0; c < NUM_CH; c++) burst_words[c] = 32'h0;
    burst_words[3] = 32'hDEAD_BEEF;
    do_burst(8'h08, "ch3_deadbeef");

    for (int r = 0; r < 6; r++) begin
      logic [NUM_CH-1:0] m;
      m = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
      for (int c = 0; c < NUM_CH; c++) burst_words[c] = $urandom;
      do_burst(m, $sformatf("rand%0d", r));
    end

    for (int c = 0; c < NUM_CH; c++) burst_words[c] = 32'h0;
    burst_words[5] = 32'h1234_5678;
    do_burst(8'h20, "ch5_parity");
    check("no_drop_yet", drop_cnt, 0);

    // ch0 on 8 consecutive edges: 5 frames, 3 drops.
    start_trace();
    add_idle(2);
    for (int e = 0; e < 8; e++) seq_words[e] = $urandom;
    for (int e = 0; e < 5; e++) add_frame(0, seq_words[e]);
    add_idle(2);
    for (int e = 0; e < 8; e++) begin
      ch_write = 8'h01;
      ch_din[31:0] = seq_words[e];
      tick();
    end
    ch_write = '0;
    finish_trace("ch0_ovf");
    rr_last = 0;
    check("ovf_drop", drop_cnt, 3);
    check("ovf_sticky", ovf_sticky, 8'h01);
    check("ovf_probe", probe_out, 1);

    // ch2 overflow, clear_stats on the same edge as a drop, then cap_en low mid-frame.
    start_trace();
    add_idle(2);
    for (int e = 0; e < 9; e++) seq_words[e] = $urandom;
    for (int e = 0; e < 5; e++) add_frame(2, seq_words[e]);
    add_idle(2);
    for (int e = 0; e < 9; e++) begin
      ch_write = 8'h04;
      ch_din[2*DATA_W +: DATA_W] = seq_words[e];
      clear_stats = (e == 7);
      cap_en = (e != 8);
      tick();
      if (e == 6) begin
        check("pre_clear_drop", drop_cnt, 5);
        check("pre_clear_ovf", ovf_sticky, 8'h05);
      end
      if (e == 7) begin
        check("clear_drop", drop_cnt, 1);
        check("clear_ovf", ovf_sticky, 8'h04);
        check("clear_probe", probe_out, 1);
      end
    end
    ch_write = '0; clear_stats = 1'b0;
    finish_trace("ch2_clear");
    rr_last = 2;
    check("capoff_full_drop", drop_cnt, 1);

    // Writes with capture disabled are ignored.
    start_trace();
    add_idle(12);
    for (int e = 0; e < 4; e++) begin
      ch_write = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
      for (int c = 0; c < NUM_CH; c++) ch_din[c*DATA_W +: DATA_W] = $urandom;
      tick();
    end
    ch_write = '0;
    finish_trace("capoff_idle");
    check("capoff_drop", drop_cnt, 1);
    check("capoff_ovf", ovf_sticky, 8'h04);
    cap_en = 1'b1;

    // Flood every channel long enough that drops exceed 16 bits.
    ch_write = '1;
    for (int e = 0; e < 9000; e++) tick();
    ch_write = '0;
    repeat (400) tick();
    check("sat_drop", drop_cnt, 16'hFFFF);
    check("sat_ovf", ovf_sticky, 8'hFF);
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    check("clr_drop", drop_cnt, 0);
    check("clr_ovf", ovf_sticky, 0);
    check("clr_probe", probe_out, 0);

    // Async reset during the 4th data beat; buffered word must be lost.
    seq_words[0] = $urandom;
    seq_words[1] = $urandom;
    ch_write = 8'h40;
    ch_din[6*DATA_W +: DATA_W] = seq_words[0];
    tick();
    ch_din[6*DATA_W +: DATA_W] = seq_words[1];
    tick();
    ch_write = '0;
    check("pre_rst_hdr", {data_valid, frame_start, data_out}, {2'b11, 4'd6});
    repeat (4) tick();
    check("pre_rst_beat", {data_valid, data_out}, {1'b1, nib_of(seq_words[0], 3)});
    #1 ap_rst_n = 1'b0;
    #1;
    check("async_valid", data_valid, 0);
    check("async_data", data_out, 0);
    #5 ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    rr_last = NUM_CH - 1;
    start_trace();
    add_idle(20);
    finish_trace("post_rst_quiet");

    // Round-robin pointer restarts at NUM_CH-1: ch0 goes before ch7.
    for (int c = 0; c < NUM_CH; c++) burst_words[c] = $urandom;
    do_burst(8'h81, "post_rst_rr");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
